// File: rtl/adc_multi_pkg.sv
// Shared types for the multi-channel RC slope ADC.
// Latency: none (types and constant functions only).
// Backpressure: not applicable.
package adc_multi_pkg;

    typedef enum logic [1:0] {
        DISCHARGE = 2'd0,
        CHARGE    = 2'd1,
        EMIT      = 2'd2
    } adc_state_e;

    // Channel index width; a single channel still gets a 1-bit index.
    function automatic int chan_w(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/adc_prescaler.sv
// Tick generator: one-cycle tick every 2^DIV_LOG2 osc cycles, synchronous restart to phase 0.
// Latency: first tick 2^DIV_LOG2-1 cycles after reset or restart.
// Backpressure: none, free running.
module adc_prescaler #(
    parameter int DIV_LOG2 = 1
) (
    input  logic osc_i,
    input  logic rst_n_i,
    input  logic restart_i,
    output logic tick_o
);

    logic [DIV_LOG2-1:0] cnt_q;
    logic [DIV_LOG2-1:0] cnt_d;

    always_comb begin
        cnt_d = restart_i ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge osc_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = &cnt_q;

endmodule

// File: rtl/adc_multi.sv
// Multi-channel RC slope ADC: shared charge line, per-channel slope timers, serial tagged result stream.
// Latency: results start 1 cycle after CHARGE ends, one channel per cycle; ADC_MULTI_AVG_EN averages 2^AVG_LOG2 frames.
// Backpressure: out_valid holds with a stable payload; the next DISCHARGE waits for the last channel transfer.
module adc_multi
    import adc_multi_pkg::*;
#(
    parameter int CHANNELS   = 4,
    parameter int OUTSIZE    = 16,
    parameter int SENSE_DIV  = 2,
    parameter int DISCH_LOG2 = 16,
    parameter int AVG_LOG2   = 2
) (
    input  logic                        osc,
    input  logic                        rst_n,
    input  logic [CHANNELS-1:0]         sense,
    output logic                        capacitor,
    output logic                        pot_1,
    output logic                        pot_2,
    output logic [OUTSIZE-1:0]          out_data,
    output logic [chan_w(CHANNELS)-1:0] out_chan,
    output logic                        out_ovf,
    output logic                        out_valid,
    input  logic                        out_ready
);

    localparam int                CW       = chan_w(CHANNELS);
    localparam logic [OUTSIZE-1:0] CNT_MAX  = '1;
    localparam logic [OUTSIZE-1:0] TMO_LAST = CNT_MAX - OUTSIZE'(1);
    localparam logic [CW-1:0]      LAST_IDX = CW'(CHANNELS - 1);

    adc_state_e state_q, state_d;

    logic [CHANNELS-1:0]              sync1_q, sync2_q;
    logic                             tick;
    logic                             enter_disch;
    logic [DISCH_LOG2-1:0]            disch_q, disch_d;
    logic [OUTSIZE-1:0]               tmo_q, tmo_d;
    logic [CHANNELS-1:0][OUTSIZE-1:0] cnt_q, cnt_d, fin_cnt;
    logic [CHANNELS-1:0]              done_q, done_d, chg_done;
    logic [CHANNELS-1:0]              ovf_q, ovf_d, fin_ovf;
    logic                             all_done, timeout, charge_end;
    logic                             frame_last, last_xfer, load;
    logic [CW-1:0]                    idx_q, idx_d, load_idx;
    logic [CHANNELS-1:0][OUTSIZE-1:0] emit_data;
    logic [CHANNELS-1:0]              emit_ovf;

    logic               out_valid_q, out_valid_d;
    logic [OUTSIZE-1:0] out_data_q, out_data_d;
    logic [CW-1:0]      out_chan_q, out_chan_d;
    logic               out_ovf_q, out_ovf_d;

    adc_prescaler #(
        .DIV_LOG2 (SENSE_DIV + 1)
    ) u_prescaler (
        .osc_i     (osc),
        .rst_n_i   (rst_n),
        .restart_i (enter_disch),
        .tick_o    (tick)
    );

    // Per-tick channel update; timeout forces unfinished channels to a saturated result.
    always_comb begin
        fin_cnt  = cnt_q;
        fin_ovf  = ovf_q;
        chg_done = done_q;
        for (int i = 0; i < CHANNELS; i++) begin
            if (!done_q[i]) begin
                if (!sync2_q[i]) begin
                    chg_done[i] = 1'b1;
                end else if (cnt_q[i] != CNT_MAX) begin
                    fin_cnt[i] = cnt_q[i] + 1'b1;
                    if (cnt_q[i] == TMO_LAST) begin
                        fin_ovf[i] = 1'b1;
                    end
                end
            end
        end
        all_done = &chg_done;
        timeout  = (tmo_q == TMO_LAST);
        if (timeout) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (!chg_done[i]) begin
                    fin_cnt[i] = CNT_MAX;
                    fin_ovf[i] = 1'b1;
                end
            end
        end
    end

    assign charge_end = tick && (all_done || timeout);
    assign last_xfer  = (state_q == EMIT) && out_valid_q && out_ready && (idx_q == LAST_IDX);

    always_ff @(posedge osc or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= DISCHARGE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            DISCHARGE: if (tick && (&disch_q)) state_d = CHARGE;
            CHARGE:    if (charge_end) state_d = frame_last ? EMIT : DISCHARGE;
            EMIT:      if (last_xfer) state_d = DISCHARGE;
            default:   state_d = DISCHARGE;
        endcase
    end

    always_comb begin
        capacitor   = (state_q == CHARGE);
        enter_disch = (state_d == DISCHARGE) && (state_q != DISCHARGE);
    end

    always_comb begin
        disch_d     = disch_q;
        tmo_d       = tmo_q;
        cnt_d       = cnt_q;
        done_d      = done_q;
        ovf_d       = ovf_q;
        idx_d       = idx_q;
        load        = 1'b0;
        load_idx    = idx_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        out_ovf_d   = out_ovf_q;
        case (state_q)
            DISCHARGE: begin
                if (tick) disch_d = disch_q + 1'b1;
                if (state_d == CHARGE) begin
                    cnt_d  = '0;
                    done_d = '0;
                    ovf_d  = '0;
                    tmo_d  = '0;
                end
            end
            CHARGE: begin
                if (tick) begin
                    cnt_d  = fin_cnt;
                    done_d = chg_done;
                    ovf_d  = fin_ovf;
                    tmo_d  = tmo_q + 1'b1;
                end
                if (charge_end) idx_d = '0;
            end
            EMIT: begin
                // out_valid is low only on the first EMIT cycle, which presents channel 0.
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                    load        = 1'b1;
                end else if (out_ready) begin
                    if (idx_q == LAST_IDX) begin
                        out_valid_d = 1'b0;
                    end else begin
                        idx_d    = idx_q + 1'b1;
                        load_idx = idx_q + 1'b1;
                        load     = 1'b1;
                    end
                end
            end
            default: ;
        endcase
        if (load) begin
            out_data_d = emit_data[load_idx];
            out_chan_d = load_idx;
            out_ovf_d  = emit_ovf[load_idx];
        end
        if (enter_disch) disch_d = '0;
    end

    always_ff @(posedge osc or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            disch_q     <= '0;
            tmo_q       <= '0;
            cnt_q       <= '0;
            done_q      <= '0;
            ovf_q       <= '0;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            sync1_q     <= sense;
            sync2_q     <= sync1_q;
            disch_q     <= disch_d;
            tmo_q       <= tmo_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
            ovf_q       <= ovf_d;
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

`ifdef ADC_MULTI_AVG_EN
    localparam int              AW         = OUTSIZE + AVG_LOG2;
    localparam int              FW         = AVG_LOG2 + 1;
    localparam logic [FW-1:0]   FRAME_LAST = FW'((1 << AVG_LOG2) - 1);

    logic [CHANNELS-1:0][AW-1:0] acc_q, acc_d;
    logic [CHANNELS-1:0]         aovf_q, aovf_d;
    logic [FW-1:0]               frame_q, frame_d;

    assign frame_last = (frame_q == FRAME_LAST);

    always_comb begin
        acc_d   = acc_q;
        aovf_d  = aovf_q;
        frame_d = frame_q;
        if ((state_q == CHARGE) && charge_end) begin
            for (int i = 0; i < CHANNELS; i++) begin
                acc_d[i] = acc_q[i] + AW'(fin_cnt[i]);
            end
            aovf_d  = aovf_q | fin_ovf;
            frame_d = frame_last ? '0 : frame_q + 1'b1;
        end
        if (last_xfer) begin
            acc_d  = '0;
            aovf_d = '0;
        end
    end

    always_comb begin
        emit_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            emit_data[i] = OUTSIZE'(acc_q[i] >> AVG_LOG2);
        end
        emit_ovf = aovf_q;
    end

    always_ff @(posedge osc or negedge rst_n) begin
        if (!rst_n) begin
            acc_q   <= '0;
            aovf_q  <= '0;
            frame_q <= '0;
        end else begin
            acc_q   <= acc_d;
            aovf_q  <= aovf_d;
            frame_q <= frame_d;
        end
    end
`else
    assign frame_last = 1'b1;

    always_comb begin
        emit_data = cnt_q;
        emit_ovf  = ovf_q;
    end
`endif

    assign pot_1     = 1'b1;
    assign pot_2     = 1'b0;
    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;
    assign out_ovf   = out_ovf_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_adc_multi.sv
// Directed bench for adc_multi: reset, conversion, timeout, back-pressure, mid-frame reset, optional averaging.
// Cycle 0 is the cycle in which rst_n is released; inputs change 1 time unit after a rising edge, outputs sampled on falling edges.
module tb_adc_multi;

    logic       osc = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] sense = 2'b11;
    logic       capacitor, pot_1, pot_2;
    logic [7:0] out_data;
    logic [0:0] out_chan;
    logic       out_ovf, out_valid;
    logic       out_ready = 1'b1;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    always #5 osc = ~osc;

    adc_multi #(
        .CHANNELS   (2),
        .OUTSIZE    (8),
        .SENSE_DIV  (0),
        .DISCH_LOG2 (4),
        .AVG_LOG2   (2)
    ) dut (
        .osc       (osc),
        .rst_n     (rst_n),
        .sense     (sense),
        .capacitor (capacitor),
        .pot_1     (pot_1),
        .pot_2     (pot_2),
        .out_data  (out_data),
        .out_chan  (out_chan),
        .out_ovf   (out_ovf),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    task automatic go(input int c);
        while (cyc < c) begin
            @(posedge osc);
            #1;
            cyc++;
        end
    endtask

    task automatic apply_reset();
        @(posedge osc);
        #1;
        rst_n = 1'b0;
        repeat (3) @(posedge osc);
        #1;
        rst_n = 1'b1;
        cyc = 0;
    endtask

    task automatic test_reset();
        sense = 2'b11;
        out_ready = 1'b1;
        @(posedge osc);
        #1;
        rst_n = 1'b0;
        @(negedge osc);
        vectors++;
        if ({capacitor, out_valid, out_ovf, out_chan, out_data, pot_1, pot_2} !== {11'h0, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_held: cap=%b valid=%b ovf=%b chan=%0d data=%0d pot1=%b pot2=%b, want 0 0 0 0 0 1 0",
                     capacitor, out_valid, out_ovf, out_chan, out_data, pot_1, pot_2);
        end
        @(posedge osc);
        #1;
        rst_n = 1'b1;
        cyc = 0;
        for (int c = 0; c <= 32; c++) begin
            go(c);
            @(negedge osc);
            vectors++;
            if ({capacitor, out_valid, out_ovf, out_chan, out_data} !== {(c >= 32), 11'h0}) begin
                miscompares++;
                $display("FAIL reset_release c%0d: cap=%b valid=%b ovf=%b chan=%0d data=%0d, want cap=%b rest 0",
                         c, capacitor, out_valid, out_ovf, out_chan, out_data, (c >= 32));
            end
        end
    endtask

    task automatic test_frame();
        sense = 2'b11;
        out_ready = 1'b1;
        apply_reset();
        go(50); sense[0] = 1'b0;
        go(80); sense[1] = 1'b0;
        go(83); @(negedge osc);
        vectors++;
        if (capacitor !== 1'b1) begin
            miscompares++;
            $display("FAIL frame_cap_high: cap=%b want 1", capacitor);
        end
        go(84); @(negedge osc);
        vectors++;
        if ({capacitor, out_valid} !== 2'b00) begin
            miscompares++;
            $display("FAIL frame_emit_entry: cap=%b valid=%b want 0 0", capacitor, out_valid);
        end
        go(85); @(negedge osc);
        vectors++;
        if ({out_valid, out_chan, out_data, out_ovf} !== {1'b1, 1'b0, 8'd10, 1'b0}) begin
            miscompares++;
            $display("FAIL frame_ch0: valid=%b chan=%0d data=%0d ovf=%b want 1 0 10 0", out_valid, out_chan, out_data, out_ovf);
        end
        go(86); @(negedge osc);
        vectors++;
        if ({out_valid, out_chan, out_data, out_ovf} !== {1'b1, 1'b1, 8'd25, 1'b0}) begin
            miscompares++;
            $display("FAIL frame_ch1: valid=%b chan=%0d data=%0d ovf=%b want 1 1 25 0", out_valid, out_chan, out_data, out_ovf);
        end
        go(87); @(negedge osc);
        sense = 2'b11;
        vectors++;
        if ({out_valid, capacitor} !== 2'b00) begin
            miscompares++;
            $display("FAIL frame_done: valid=%b cap=%b want 0 0", out_valid, capacitor);
        end
        go(118); @(negedge osc);
        vectors++;
        if (capacitor !== 1'b0) begin
            miscompares++;
            $display("FAIL frame_next_disch: cap=%b want 0", capacitor);
        end
        go(119); @(negedge osc);
        vectors++;
        if (capacitor !== 1'b1) begin
            miscompares++;
            $display("FAIL frame_next_charge: cap=%b want 1", capacitor);
        end
    endtask

    task automatic test_timeout();
        sense = 2'b11;
        out_ready = 1'b1;
        apply_reset();
        go(40); sense[0] = 1'b0;
        go(541); @(negedge osc);
        vectors++;
        if (capacitor !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_last_tick: cap=%b want 1", capacitor);
        end
        go(542); @(negedge osc);
        vectors++;
        if (capacitor !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_exit: cap=%b want 0", capacitor);
        end
        go(543); @(negedge osc);
        vectors++;
        if ({out_valid, out_chan, out_data, out_ovf} !== {1'b1, 1'b0, 8'd5, 1'b0}) begin
            miscompares++;
            $display("FAIL timeout_ch0: valid=%b chan=%0d data=%0d ovf=%b want 1 0 5 0", out_valid, out_chan, out_data, out_ovf);
        end
        go(544); @(negedge osc);
        vectors++;
        if ({out_valid, out_chan, out_data, out_ovf} !== {1'b1, 1'b1, 8'd255, 1'b1}) begin
            miscompares++;
            $display("FAIL timeout_ch1: valid=%b chan=%0d data=%0d ovf=%b want 1 1 255 1", out_valid, out_chan, out_data, out_ovf);
        end
    endtask

    task automatic test_back_pressure();
        sense = 2'b11;
        out_ready = 1'b1;
        apply_reset();
        go(50); sense[0] = 1'b0;
        go(60); sense[1] = 1'b0;
        go(64); out_ready = 1'b0;
        @(negedge osc);
        vectors++;
        if ({capacitor, out_valid} !== 2'b00) begin
            miscompares++;
            $display("FAIL bp_entry: cap=%b valid=%b want 0 0", capacitor, out_valid);
        end
        for (int c = 65; c <= 69; c++) begin
            go(c);
            if (c == 69) out_ready = 1'b1;
            @(negedge osc);
            vectors++;
            if ({capacitor, out_valid, out_chan, out_data, out_ovf} !== {1'b0, 1'b1, 1'b0, 8'd10, 1'b0}) begin
                miscompares++;
                $display("FAIL bp_hold c%0d: cap=%b valid=%b chan=%0d data=%0d ovf=%b want 0 1 0 10 0",
                         c, capacitor, out_valid, out_chan, out_data, out_ovf);
            end
        end
        go(70); @(negedge osc);
        vectors++;
        if ({capacitor, out_valid, out_chan, out_data, out_ovf} !== {1'b0, 1'b1, 1'b1, 8'd15, 1'b0}) begin
            miscompares++;
            $display("FAIL bp_ch1: cap=%b valid=%b chan=%0d data=%0d ovf=%b want 0 1 1 15 0",
                     capacitor, out_valid, out_chan, out_data, out_ovf);
        end
        go(71); @(negedge osc);
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_done: valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_reset_mid();
        sense = 2'b11;
        out_ready = 1'b1;
        apply_reset();
        go(40); @(negedge osc);
        vectors++;
        if (capacitor !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_charge: cap=%b want 1", capacitor);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({capacitor, out_valid} !== 2'b00) begin
            miscompares++;
            $display("FAIL mid_reset_async: cap=%b valid=%b want 0 0", capacitor, out_valid);
        end
        @(posedge osc);
        #1;
        rst_n = 1'b1;
        cyc = 0;
        go(31); @(negedge osc);
        vectors++;
        if (capacitor !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_redisch: cap=%b want 0", capacitor);
        end
        go(32); @(negedge osc);
        vectors++;
        if (capacitor !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_recharge: cap=%b want 1", capacitor);
        end
        go(40);
        sense = 2'b00;
        out_ready = 1'b0;
        go(46); @(negedge osc);
        vectors++;
        if ({out_valid, out_chan, out_data} !== {1'b1, 1'b0, 8'd5}) begin
            miscompares++;
            $display("FAIL mid_emit: valid=%b chan=%0d data=%0d want 1 0 5", out_valid, out_chan, out_data);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({out_valid, out_data, capacitor} !== 10'h0) begin
            miscompares++;
            $display("FAIL mid_emit_reset: valid=%b data=%0d cap=%b want 0 0 0", out_valid, out_data, capacitor);
        end
        @(posedge osc);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        sense = 2'b11;
    endtask

`ifdef ADC_MULTI_AVG_EN
    task automatic test_average();
        sense = 2'b11;
        out_ready = 1'b1;
        apply_reset();
        for (int c = 0; c <= 299; c++) begin
            go(c);
            for (int k = 0; k < 4; k++) begin
                automatic int cs = 32 + 74 * k;
                if (c == cs + 18 + 2 * k) sense[0] = 1'b0;
                if (c == cs + 38) sense[1] = 1'b0;
                if (c == cs + 42) sense = 2'b11;
            end
            @(negedge osc);
            if (c < 297) begin
                vectors++;
                if (out_valid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL avg_early c%0d: valid=%b want 0", c, out_valid);
                end
            end else if (c == 297) begin
                vectors++;
                if ({out_valid, out_chan, out_data, out_ovf} !== {1'b1, 1'b0, 8'd11, 1'b0}) begin
                    miscompares++;
                    $display("FAIL avg_ch0: valid=%b chan=%0d data=%0d ovf=%b want 1 0 11 0", out_valid, out_chan, out_data, out_ovf);
                end
            end else if (c == 298) begin
                vectors++;
                if ({out_valid, out_chan, out_data, out_ovf} !== {1'b1, 1'b1, 8'd20, 1'b0}) begin
                    miscompares++;
                    $display("FAIL avg_ch1: valid=%b chan=%0d data=%0d ovf=%b want 1 1 20 0", out_valid, out_chan, out_data, out_ovf);
                end
            end else begin
                vectors++;
                if (out_valid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL avg_done: valid=%b want 0", out_valid);
                end
            end
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_frame();
        test_timeout();
        test_back_pressure();
        test_reset_mid();
`ifdef ADC_MULTI_AVG_EN
        test_average();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
